// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the multi-cycle core and the memory responder.
// The core drives opcodes, address and store data; the responder returns load data and status.
interface mem_ctrl_if;
    logic [2:0]  read_op;
    logic [1:0]  write_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output read_op, write_op, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  read_op, write_op, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory responder: serialises byte/halfword/word loads and stores onto a byte-wide
// synchronous single-port RAM, extends load data and rejects illegal or misaligned requests.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_ctrl_if.slave             bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [2:0] LB    = 3'b000;
    localparam logic [2:0] LH    = 3'b001;
    localparam logic [2:0] LW    = 3'b010;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;
    localparam logic [2:0] LNONE = 3'b111;
    localparam logic [1:0] SH    = 2'b01;
    localparam logic [1:0] SW    = 2'b10;
    localparam logic [1:0] SNONE = 2'b11;

    state_t                state_q, state_d;
    logic [2:0]            rop_q, rop_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;

    logic                  rd_req;
    logic                  wr_req;
    logic                  reject;
    logic [2:0]            req_n;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            cap_idx;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH];

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] v);
        case (op)
            LB:      extend = {{24{v[7]}}, v[7:0]};
            LH:      extend = {{16{v[15]}}, v[15:0]};
            LBU:     extend = {24'h0, v[7:0]};
            LHU:     extend = {16'h0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    always_comb begin
        rd_req = bus.read_op != LNONE;
        wr_req = bus.write_op != SNONE;
        req_n  = 3'd1;
        if (rd_req) begin
            case (bus.read_op)
                LH, LHU: req_n = 3'd2;
                LW:      req_n = 3'd4;
                default: req_n = 3'd1;
            endcase
        end else begin
            case (bus.write_op)
                SH:      req_n = 3'd2;
                SW:      req_n = 3'd4;
                default: req_n = 3'd1;
            endcase
        end
        reject = (bus.read_op == 3'b011) || (bus.read_op == 3'b110) || (rd_req && wr_req)
               || (req_n == 3'd2 && bus.addr[0])
               || (req_n == 3'd4 && bus.addr[1:0] != 2'b00);
        req_base  = bus.addr[ADDR_WIDTH-1:0];
        next_addr = base_q + {{(ADDR_WIDTH-3){1'b0}}, idx_q};
        // In RD, idx counts cycles since acceptance; the byte returning now was issued two cycles ago.
        cap_idx   = idx_q[1:0] - 2'd2;
    end

    always_comb begin
        state_d     = state_q;
        rop_d       = rop_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    busy_d = 1'b1;
                    if (reject) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        if (rd_req) begin
                            rdata_d = '0;
                        end
                    end else begin
                        rop_d      = bus.read_op;
                        nbytes_d   = req_n;
                        base_d     = req_base;
                        wdata_d    = bus.wdata;
                        idx_d      = 3'd1;
                        asm_d      = '0;
                        ram_addr_d = req_base;
                        if (rd_req) begin
                            state_d = RD;
                        end else begin
                            state_d     = WR;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = bus.wdata[7:0];
                        end
                    end
                end
            end
            WR: begin
                if (idx_q == nbytes_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = next_addr;
                    ram_wdata_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                    idx_d       = idx_q + 3'd1;
                end
            end
            RD: begin
                if (idx_q < nbytes_q) begin
                    ram_addr_d = next_addr;
                end
                if (idx_q >= 3'd2) begin
                    asm_d[{cap_idx, 3'b000} +: 8] = ram_rdata;
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == nbytes_q + 3'd1) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    rdata_d = extend(rop_q, asm_d);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rop_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rop_q       <= rop_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed load/store vectors, a transaction-timing reference model
// compared on every cycle, and hand-computed spot checks of latency and load data.
module tb_mem_ctrl;
    localparam int AW = 16;

    localparam logic [2:0] R_LB   = 3'b000;
    localparam logic [2:0] R_LH   = 3'b001;
    localparam logic [2:0] R_LW   = 3'b010;
    localparam logic [2:0] R_LBU  = 3'b100;
    localparam logic [2:0] R_LHU  = 3'b101;
    localparam logic [2:0] R_NONE = 3'b111;
    localparam logic [1:0] W_SB   = 2'b00;
    localparam logic [1:0] W_SH   = 2'b01;
    localparam logic [1:0] W_SW   = 2'b10;
    localparam logic [1:0] W_NONE = 2'b11;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    mem_ctrl_if bus();

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [0:65535];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0]    ref_mem [0:65535];
    bit            m_active = 1'b0;
    bit            m_read   = 1'b0;
    bit            m_reject = 1'b0;
    bit            m_signed = 1'b0;
    int            m_start  = 0;
    int            m_n      = 1;
    int            m_done   = 0;
    logic [AW-1:0] m_base   = '0;
    logic [31:0]   m_wdata  = '0;
    logic [31:0]   e_rdata  = '0;
    logic          e_busy   = 1'b0;
    logic          e_done   = 1'b0;
    logic          e_err    = 1'b0;
    logic          e_we     = 1'b0;
    logic [AW-1:0] e_addr   = '0;
    logic [7:0]    e_wdata  = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: at each edge decide what the outputs of the coming cycle must be,
    // from the access start cycle, byte count and the documented latencies.
    initial begin : model
        int          t;
        logic [31:0] v;
        forever begin
            @(posedge clk);
            if (e_we) ref_mem[e_addr] = e_wdata;
            t = cyc + 1;
            if (reset) begin
                m_active = 1'b0;
                e_rdata  = '0;
                e_busy   = 1'b0;
                e_done   = 1'b0;
                e_err    = 1'b0;
                e_we     = 1'b0;
                e_addr   = '0;
                e_wdata  = '0;
            end else begin
                if (m_active && cyc == m_done) begin
                    m_active = 1'b0;
                end else if (!m_active && (bus.read_op != R_NONE || bus.write_op != W_NONE)) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_base   = bus.addr[AW-1:0];
                    m_wdata  = bus.wdata;
                    m_read   = bus.read_op != R_NONE;
                    m_signed = 1'b0;
                    m_reject = 1'b0;
                    if (m_read) begin
                        case (bus.read_op)
                            R_LB:    begin m_n = 1; m_signed = 1'b1; end
                            R_LH:    begin m_n = 2; m_signed = 1'b1; end
                            R_LW:    m_n = 4;
                            R_LBU:   m_n = 1;
                            R_LHU:   m_n = 2;
                            default: begin m_n = 1; m_reject = 1'b1; end
                        endcase
                        if (bus.write_op != W_NONE) m_reject = 1'b1;
                    end else begin
                        m_n = (bus.write_op == W_SB) ? 1 : (bus.write_op == W_SH) ? 2 : 4;
                    end
                    if (int'(m_base) % m_n != 0) m_reject = 1'b1;
                    if (m_reject)    m_done = cyc + 1;
                    else if (m_read) m_done = cyc + m_n + 2;
                    else             m_done = cyc + m_n + 1;
                    if (m_reject && m_read) e_rdata = '0;
                end
                e_we = 1'b0;
                if (m_active && !m_reject && t > m_start && t <= m_start + m_n) begin
                    e_addr = m_base + AW'(t - m_start - 1);
                    if (!m_read) begin
                        e_we    = 1'b1;
                        e_wdata = m_wdata[8*(t - m_start - 1) +: 8];
                    end
                end
                if (m_active && m_read && !m_reject && t == m_done) begin
                    v = '0;
                    for (int k = 0; k < m_n; k++) v = v + (32'(ref_mem[m_base + AW'(k)]) << (8*k));
                    if (m_signed && v[8*m_n-1]) v = v | (32'hFFFF_FFFF << (8*m_n));
                    e_rdata = v;
                end
                e_busy = m_active;
                e_done = m_active && t == m_done;
                e_err  = e_done && m_reject;
            end
            cyc++;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                checkOutput("busy",      32'(bus.busy),  32'(e_busy));
                checkOutput("done",      32'(bus.done),  32'(e_done));
                checkOutput("err",       32'(bus.err),   32'(e_err));
                checkOutput("rdata",     bus.rdata,      e_rdata);
                checkOutput("ram_we",    32'(ram_we),    32'(e_we));
                checkOutput("ram_addr",  32'(ram_addr),  32'(e_addr));
                checkOutput("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] rop, input logic [1:0] wop,
                                 input logic [31:0] a, input logic [31:0] w,
                                 output int lat, output logic [31:0] rd, output logic er);
        int start;
        bit seen;
        @(negedge clk);
        bus.read_op  = rop;
        bus.write_op = wop;
        bus.addr     = a;
        bus.wdata    = w;
        start = cyc;
        lat   = -1;
        rd    = '0;
        er    = 1'b0;
        seen  = 1'b0;
        @(negedge clk);
        bus.read_op  = R_NONE;
        bus.write_op = W_NONE;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - start;
                rd   = bus.rdata;
                er   = bus.err;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL done_timeout: no done within 12 cycles, expected one (cycle %0d)", cyc);
        end
    endtask

    logic [2:0]  rj_rop  [4] = '{R_LW, R_LH, 3'b011, R_LW};
    logic [1:0]  rj_wop  [4] = '{W_NONE, W_NONE, W_NONE, W_SW};
    logic [31:0] rj_addr [4] = '{32'h102, 32'h201, 32'h100, 32'h100};

    initial begin : stimulus
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          start;
        int          nd;
        int          d1;
        int          d2;
        bus.read_op  = R_NONE;
        bus.write_op = W_NONE;
        bus.addr     = '0;
        bus.wdata    = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy",     32'(bus.busy), 32'h0);
        checkOutput("reset_done",     32'(bus.done), 32'h0);
        checkOutput("reset_ram_we",   32'(ram_we),   32'h0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("reset_rdata",    bus.rdata,     32'h0);

        applyStimulus(R_NONE, W_SW, 32'h100, 32'h4433_2211, lat, rd, er);
        checkOutput("sw_latency", 32'(lat), 32'd5);
        applyStimulus(R_LW, W_NONE, 32'h100, 32'h0, lat, rd, er);
        checkOutput("lw_latency", 32'(lat), 32'd6);
        checkOutput("lw_rdata",   rd,       32'h4433_2211);
        checkOutput("lw_err",     32'(er),  32'h0);

        applyStimulus(R_NONE, W_SB, 32'h101, 32'h0000_0080, lat, rd, er);
        checkOutput("sb_latency", 32'(lat), 32'd2);
        applyStimulus(R_LB, W_NONE, 32'h101, 32'h0, lat, rd, er);
        checkOutput("lb_latency", 32'(lat), 32'd3);
        checkOutput("lb_rdata",   rd,       32'hFFFF_FF80);
        applyStimulus(R_LBU, W_NONE, 32'h101, 32'h0, lat, rd, er);
        checkOutput("lbu_rdata",  rd,       32'h0000_0080);

        applyStimulus(R_NONE, W_SH, 32'h200, 32'h0000_9234, lat, rd, er);
        applyStimulus(R_LH, W_NONE, 32'h200, 32'h0, lat, rd, er);
        checkOutput("lh_latency", 32'(lat), 32'd4);
        checkOutput("lh_rdata",   rd,       32'hFFFF_9234);
        applyStimulus(R_LHU, W_NONE, 32'h200, 32'h0, lat, rd, er);
        checkOutput("lhu_rdata",  rd,       32'h0000_9234);

        applyStimulus(R_NONE, W_SB, 32'h204, 32'h0000_005A, lat, rd, er);
        applyStimulus(R_NONE, W_SH, 32'h202, 32'h1234_BEEF, lat, rd, er);
        checkOutput("sh_latency",   32'(lat),           32'd3);
        checkOutput("sh_rdata_kept", rd,                32'h0000_9234);
        checkOutput("sh_mem_202",   32'(ram_mem[16'h202]), 32'h0000_00EF);
        checkOutput("sh_mem_203",   32'(ram_mem[16'h203]), 32'h0000_00BE);
        checkOutput("sh_mem_204",   32'(ram_mem[16'h204]), 32'h0000_005A);
        applyStimulus(R_LHU, W_NONE, 32'h202, 32'h0, lat, rd, er);
        checkOutput("lhu_202_rdata", rd, 32'h0000_BEEF);

        // Each rejection is preceded by a load so that the forced-zero rdata is observable.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(R_LBU, W_NONE, 32'h204, 32'h0, lat, rd, er);
            checkOutput("pre_reject_rdata", rd, 32'h0000_005A);
            applyStimulus(rj_rop[i], rj_wop[i], rj_addr[i], 32'h0, lat, rd, er);
            checkOutput("reject_latency", 32'(lat), 32'd1);
            checkOutput("reject_err",     32'(er),  32'h1);
            checkOutput("reject_rdata",   rd,       32'h0);
        end
        applyStimulus(R_LBU, W_NONE, 32'h204, 32'h0, lat, rd, er);
        applyStimulus(R_NONE, W_SW, 32'h302, 32'h1111_1111, lat, rd, er);
        checkOutput("reject_sw_err",   32'(er), 32'h1);
        checkOutput("reject_sw_rdata", rd,      32'h0000_005A);

        applyStimulus(R_NONE, W_SB, 32'h302, 32'h0000_0077, lat, rd, er);
        @(negedge clk);
        bus.write_op = W_SW;
        bus.addr     = 32'h300;
        bus.wdata    = 32'hAABB_CCDD;
        start = cyc;
        @(negedge clk);
        bus.write_op = W_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_cycle",    32'(cyc - start), 32'd3);
        checkOutput("abort_busy",     32'(bus.busy),    32'h0);
        checkOutput("abort_ram_we",   32'(ram_we),      32'h0);
        checkOutput("abort_ram_addr", 32'(ram_addr),    32'h0);
        nd = 0;
        repeat (6) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(nd), 32'd0);
        applyStimulus(R_LBU, W_NONE, 32'h300, 32'h0, lat, rd, er);
        checkOutput("abort_byte0", rd, 32'h0000_00DD);
        applyStimulus(R_LBU, W_NONE, 32'h301, 32'h0, lat, rd, er);
        checkOutput("abort_byte1", rd, 32'h0000_00CC);
        applyStimulus(R_LBU, W_NONE, 32'h302, 32'h0, lat, rd, er);
        checkOutput("abort_byte2", rd, 32'h0000_0077);

        @(negedge clk);
        bus.read_op = R_LW;
        bus.addr    = 32'h100;
        start = cyc;
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 < 0)      d1 = cyc - start;
                else if (d2 < 0) d2 = cyc - start;
            end
        end
        bus.read_op = R_NONE;
        checkOutput("held_first_done",  32'(d1), 32'd6);
        checkOutput("held_second_done", 32'(d2), 32'd13);
        for (int k = 0; k < 12 && bus.busy; k++) @(negedge clk);
        checkOutput("drain_idle", 32'(bus.busy), 32'h0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory responder for the multi-cycle core. It accepts the load/store opcodes issued by the control unit (`mem_read_op`/`mem_write_op` encodings), serialises each access onto a byte-wide synchronous single-port RAM, and returns sign- or zero-extended load data. It reports completion with `busy`/`done` and flags misaligned or illegal requests.

## Interface
- ADDR_WIDTH, 16, width of the byte address driven to the RAM.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  reset, synchronous, active-high.
- read_op  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101, LNONE=111; 011 and 110 are illegal.
- write_op  in  2  SB=00, SH=01, SW=10, SNONE=11.
- addr  in  32  byte address; only [ADDR_WIDTH-1:0] is used.
- wdata  in  32  store data; low bytes are used per the op width.
- rdata  out  32  extended load result.
- busy  out  1  an accepted access is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with `done`, on a rejected request.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; valid the cycle after its address is presented.

## Operation
- States: IDLE, RD, WR, FIN.
- Request detection (IDLE only): a request is `read_op != LNONE` or `write_op != SNONE`, sampled at the rising edge. Requests arriving while `busy=1` are ignored. No queueing.
- Byte count N: B/BU/SB = 1, H/HU/SH = 2, W/SW = 4.
- Rejected requests:
  - illegal read_op (011, 110);
  - read and write both active;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
  - Rejection goes IDLE→FIN with no RAM access. `err=1` and `done=1` in FIN; rdata is forced to 0 on a rejected read and left unchanged on a rejected write.
- Accepted request: latch op, base = addr[ADDR_WIDTH-1:0], and wdata. Clear the byte index i=0 and go to RD or WR.
- Byte order is little-endian: byte i is at base+i and holds bits [8i+7:8i]. Address arithmetic is modulo 2^ADDR_WIDTH.
- WR state:
  - Each cycle drives ram_addr=base+i, ram_we=1, ram_wdata=wdata byte i, then increments i.
  - After byte N-1, go to FIN.
- RD state:
  - Each cycle drives ram_addr=base+i with ram_we=0.
  - ram_rdata is captured one cycle later into assembly byte i-1, so capture overlaps the next issue.
  - After issuing byte N-1, the next cycle captures the last byte, then goes to FIN.
- Extension is applied when rdata is updated:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU/LHU zero-extend; LW passes through unchanged.
- FIN: `done=1`, `busy=1`, then go to IDLE.
- rdata holds its value until the next completed or rejected read. Writes never change rdata.
- ram_we is 1 only in WR. Outside WR, ram_addr and ram_wdata hold their last values.

## Timing
- Let cycle A be the cycle in which the request is sampled in IDLE.
- Write: byte i is on the RAM in cycle A+1+i. `done` is in cycle A+N+1.
  - Latency: SB 2, SH 3, SW 5.
- Read: address i is in cycle A+1+i and data i is captured at the end of cycle A+2+i. `done`, with rdata valid, is in cycle A+N+2.
  - Latency: LB 3, LH 4, LW 6.
- Rejected request: `done`/`err` are in cycle A+1.
- `busy` is 1 from cycle A+1 through the `done` cycle inclusive. The earliest next request is sampled in the cycle after `done`.
- Reset values: state IDLE; busy, done, err, ram_we = 0; ram_addr = 0, ram_wdata = 0, rdata = 0.
- Reset mid-access: the access aborts at that edge.
  - ram_we is 0 from the next cycle.
  - No `done` is produced for the aborted access.
  - Bytes already written remain written.
- Reset has priority over any request sampled at the same edge.

## Test plan
- RAM 0x100..0x103 = 11 22 33 44; LW at 0x100 requested in cycle 0 → ram_addr 0x100..0x103 in cycles 1..4, done in cycle 6, rdata=0x44332211, busy=1 in cycles 1..6.
- RAM 0x101 = 0x80; LB at 0x101 → rdata=0xFFFFFF80 in cycle 3. LBU at the same address → rdata=0x00000080. RAM 0x200..0x201 = 0x34 0x92 with LH → 0xFFFF9234; LHU → 0x00009234.
- SH wdata=0x1234BEEF at 0x202 → ram_we=1, 0xEF@0x202 in cycle 1, 0xBE@0x203 in cycle 2, done in cycle 3; 0x204 is never written; rdata unchanged.
- Rejections, each producing done=err=1 in cycle 1, no ram_we, rdata=0:
  - LW at 0x102;
  - LH at 0x201;
  - read_op=011;
  - LW with SW at the same time.
- SW 0xAABBCCDD at 0x300 with reset asserted in cycle 2 → only 0xDD@0x300 and 0xCC@0x301 are written; all outputs are at reset values from cycle 3; no done.
- LW held on the inputs continuously → re-sampled in cycle 7 (the cycle after done) and never during busy; a second done is in cycle 13.
